byte_word_packer: RTL and testbench
===================================

BYTE_WORD_PACKER -- requirements
Module: byte_word_packer

Interface
REQ-001 SHALL have parameter NUM_BYTES, default 4, bytes per output word; legal range 2..8.
REQ-002 SHALL have port clk  input  1  sole clock; all state updates on rising edge.
REQ-003 SHALL have port rst_n  input  1  reset; synchronous, active-low.
REQ-004 SHALL have port in_valid  input  1  upstream byte valid.
REQ-005 SHALL have port in_ready  output  1  packer can accept a byte this cycle.
REQ-006 SHALL have port in_data  input  8  byte payload.
REQ-007 SHALL have port in_last  input  1  byte ends the current packet.
REQ-008 SHALL have port out_valid  output  1  packed word valid.
REQ-009 SHALL have port out_ready  input  1  downstream accepts the word.
REQ-010 SHALL have port out_data  output  8*NUM_BYTES  packed word; first byte in the most significant lane.
REQ-011 SHALL have port out_keep  output  NUM_BYTES  per-lane filled flag; bit NUM_BYTES-1 = first lane.
REQ-012 SHALL have port out_last  output  1  word closed by in_last.

Function
REQ-013 SHALL accept a byte when in_valid && in_ready, and SHALL drive in_ready = !out_valid || out_ready, independent of in_valid, in_data and in_last.
REQ-014 SHALL hold an accumulator and lane index idx (0..NUM_BYTES-1); accepted byte k of a word SHALL land in lane bits [8*(NUM_BYTES-k)-1 : 8*(NUM_BYTES-k)-8].
REQ-015 SHALL keep a two-state FSM: IDLE (idx=0, accumulator empty) -> FILL on an accepted byte that does not close the word; FILL -> IDLE on an accepted byte with idx=NUM_BYTES-1 or in_last=1.
REQ-016 SHALL close the word on an accepted byte with idx=NUM_BYTES-1 or in_last=1 (including a single in_last byte in IDLE), then copy it to the output register in the same edge; out_valid SHALL rise the next cycle (latency 1 cycle from the closing byte).
REQ-017 SHALL zero unfilled lanes of out_data and clear their out_keep bits; a full word SHALL have out_keep all ones.
REQ-018 SHALL set out_last=1 only if the closing byte had in_last=1; in_last on byte NUM_BYTES-1 SHALL give full keep and out_last=1.
REQ-019 SHALL hold out_data, out_keep, out_last and out_valid stable while out_valid && !out_ready.
REQ-020 SHALL clear out_valid after out_valid && out_ready unless a new word closes on the same edge, in which case out_valid SHALL stay 1 and the output register SHALL load the new word with no bubble.
REQ-021 SHALL sustain one byte per cycle with out_ready held high (one word every NUM_BYTES cycles).
REQ-022 SHALL ignore in_data and in_last when in_valid=0 or in_ready=0; idx SHALL not advance.

Reset
REQ-023 SHALL, on rising edge with rst_n=0, set FSM=IDLE, idx=0, accumulator=0, out_valid=0, out_data=0, out_keep=0, out_last=0 (parity 0 when compiled in).
REQ-024 SHALL discard a partially filled word and any unaccepted output word on reset mid-operation; no word SHALL appear after reset until new bytes close one.
REQ-025 SHALL drive in_ready=1 in the first cycle after reset release.

Configuration
REQ-026 SHALL, with macro BYTE_WORD_PACKER_PARITY_EN defined, add output out_parity [NUM_BYTES] = even parity per lane of out_data (0 for unfilled lanes), registered and held with out_data.
REQ-027 SHALL, without BYTE_WORD_PACKER_PARITY_EN, omit out_parity entirely; all other behaviour identical.

Verification (NUM_BYTES=4)
REQ-028 SHALL verify bytes 0x11,0x22,0x33,0x44 back-to-back, out_ready=1 -> one cycle after 0x44: out_data=0x11223344, out_keep=4'b1111, out_last=0, in_ready never low.
REQ-029 SHALL verify 0xAA,0xBB with in_last on 0xBB -> out_data=0xAABB0000, out_keep=4'b1100, out_last=1; a single in_last byte 0x5A in IDLE -> 0x5A000000, keep 4'b1000.
REQ-030 SHALL verify out_ready=0 for 6 cycles after a word -> out_data stable, in_ready=0, a held in_valid byte not accepted until out_ready rises.
REQ-031 SHALL verify continuous 12-byte stream 0x00..0x0B, out_ready=1 -> words 0x00010203, 0x04050607, 0x08090A0B on consecutive 4-cycle boundaries with out_valid never dropping between closing edge and handshake.
REQ-032 SHALL verify rst_n=0 for one cycle after two bytes 0xC0,0xC1, then 0x01..0x04 -> only word 0x01020304 emitted.
REQ-033 SHALL verify, with BYTE_WORD_PACKER_PARITY_EN, word 0x01030700 keep 4'b1110 -> out_parity=4'b1010.

Source files
------------

// File: rtl/byte_word_packer.sv
// Packs an accepted byte stream into NUM_BYTES-wide words, first byte in the most significant lane.
// Optional feature macro BYTE_WORD_PACKER_PARITY_EN adds out_parity (even parity per output lane).
module byte_word_packer #(
   parameter int NUM_BYTES = 4
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   in_valid,
   output logic                   in_ready,
   input  logic [7:0]             in_data,
   input  logic                   in_last,
   output logic                   out_valid,
   input  logic                   out_ready,
   output logic [8*NUM_BYTES-1:0] out_data,
   output logic [NUM_BYTES-1:0]   out_keep,
   output logic                   out_last
`ifdef BYTE_WORD_PACKER_PARITY_EN
   ,
   output logic [NUM_BYTES-1:0]   out_parity
`endif
);

   localparam int WORD_W = 8 * NUM_BYTES;
   localparam int IDX_W  = $clog2(NUM_BYTES);
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_BYTES - 1);

   typedef enum logic {
      IDLE = 1'b0,
      FILL = 1'b1
   } state_t;

   state_t              state_p0;
   logic [IDX_W-1:0]    idx_p0;
   logic [WORD_W-1:0]   acc_p0;
   logic [NUM_BYTES-1:0] keep_p0;

   logic                accept;
   logic                closing;
   logic [IDX_W-1:0]    lane;
   logic [WORD_W-1:0]   word_nxt;
   logic [NUM_BYTES-1:0] keep_nxt;

   function automatic logic [WORD_W-1:0] place_byte(input logic [7:0] b,
                                                    input logic [IDX_W-1:0] k);
      logic [WORD_W-1:0] w;
      w = '0;
      w[WORD_W - 1 - 8 * int'(k) -: 8] = b;
      return w;
   endfunction

   function automatic logic [NUM_BYTES-1:0] lane_mask(input logic [IDX_W-1:0] k);
      logic [NUM_BYTES-1:0] m;
      m = '0;
      m[NUM_BYTES - 1 - int'(k)] = 1'b1;
      return m;
   endfunction

`ifdef BYTE_WORD_PACKER_PARITY_EN
   function automatic logic [NUM_BYTES-1:0] lane_parity(input logic [WORD_W-1:0] w);
      logic [NUM_BYTES-1:0] p;
      for (int i = 0; i < NUM_BYTES; i++) begin
         p[i] = ^w[8*i +: 8];
      end
      return p;
   endfunction
`endif

   // Accumulator lanes are cleared on every close, so OR-ing in the new byte is enough.
   always_comb begin
      in_ready = !out_valid || out_ready;
      accept   = in_valid && in_ready;
      lane     = (state_p0 == IDLE) ? '0 : idx_p0;
      closing  = accept && ((lane == LAST_IDX) || in_last);
      word_nxt = acc_p0 | place_byte(in_data, lane);
      keep_nxt = keep_p0 | lane_mask(lane);
   end

   // Stage p0: accumulate; closing byte copies straight into the output register.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_p0   <= IDLE;
         idx_p0     <= '0;
         acc_p0     <= '0;
         keep_p0    <= '0;
         out_valid  <= 1'b0;
         out_data   <= '0;
         out_keep   <= '0;
         out_last   <= 1'b0;
`ifdef BYTE_WORD_PACKER_PARITY_EN
         out_parity <= '0;
`endif
      end else begin
         if (out_valid && out_ready) begin
            out_valid <= 1'b0;
         end
         if (accept) begin
            if (closing) begin
               state_p0   <= IDLE;
               idx_p0     <= '0;
               acc_p0     <= '0;
               keep_p0    <= '0;
               out_valid  <= 1'b1;
               out_data   <= word_nxt;
               out_keep   <= keep_nxt;
               out_last   <= in_last;
`ifdef BYTE_WORD_PACKER_PARITY_EN
               out_parity <= lane_parity(word_nxt);
`endif
            end else begin
               state_p0 <= FILL;
               idx_p0   <= lane + IDX_W'(1);
               acc_p0   <= word_nxt;
               keep_p0  <= keep_nxt;
            end
         end
      end
   end

endmodule

// File: tb/tb_byte_word_packer.sv
// Scoreboard bench for byte_word_packer (NUM_BYTES=4); define BYTE_WORD_PACKER_PARITY_EN to cover out_parity.
module tb_byte_word_packer;

   localparam int NB = 4;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        in_valid = 1'b0;
   logic        in_ready;
   logic [7:0]  in_data = 8'h00;
   logic        in_last = 1'b0;
   logic        out_valid;
   logic        out_ready = 1'b0;
   logic [31:0] out_data;
   logic [3:0]  out_keep;
   logic        out_last;
`ifdef BYTE_WORD_PACKER_PARITY_EN
   logic [3:0]  out_parity;
`endif

   int errors = 0;
   int checks = 0;
   int cyc = 0;

   typedef struct packed {
      logic [31:0] data;
      logic [3:0]  keep;
      logic        last;
   } word_t;

   word_t       exp_q[$];
   logic [31:0] got_q[$];
   int          hs_q[$];
   word_t       mon_e;
   word_t       mon_w;
   logic [31:0] m_acc = '0;
   logic [3:0]  m_keep = '0;
   int          m_idx = 0;

   byte_word_packer #(.NUM_BYTES(NB)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_data   (in_data),
      .in_last   (in_last),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (out_data),
      .out_keep  (out_keep),
      .out_last  (out_last)
`ifdef BYTE_WORD_PACKER_PARITY_EN
      ,
      .out_parity(out_parity)
`endif
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   // Reference model and output scoreboard, sampled mid-cycle ahead of the deciding edge.
   always @(negedge clk) begin
      if (!rst_n) begin
         m_acc = '0;
         m_keep = '0;
         m_idx = 0;
         exp_q.delete();
      end else begin
         if (out_valid && out_ready) begin
            checks++;
            mon_w = '{data: out_data, keep: out_keep, last: out_last};
            if (exp_q.size() == 0) begin
               errors++;
               $display("FAIL scoreboard_unexpected: got data=%h keep=%b last=%b, required no word", out_data, out_keep, out_last);
            end else begin
               mon_e = exp_q.pop_front();
               if (mon_w !== mon_e) begin
                  errors++;
                  $display("FAIL scoreboard_word: got data=%h keep=%b last=%b, required data=%h keep=%b last=%b",
                           mon_w.data, mon_w.keep, mon_w.last, mon_e.data, mon_e.keep, mon_e.last);
               end
            end
            got_q.push_back(out_data);
            hs_q.push_back(cyc);
         end
         if (in_valid && in_ready) begin
            m_acc[8*(NB-m_idx)-1 -: 8] = in_data;
            m_keep[NB-1-m_idx] = 1'b1;
            if (m_idx == NB-1 || in_last) begin
               exp_q.push_back('{data: m_acc, keep: m_keep, last: in_last});
               m_acc = '0;
               m_keep = '0;
               m_idx = 0;
            end else begin
               m_idx++;
            end
         end
      end
   end

   task automatic send_byte(input logic [7:0] d, input logic l, output int stall);
      stall = 0;
      in_valid = 1'b1;
      in_data = d;
      in_last = l;
      @(negedge clk);
      while (!in_ready && stall < 100) begin
         stall++;
         @(negedge clk);
      end
      if (stall >= 100) begin
         checks++;
         errors++;
         $display("FAIL send_timeout: byte %h waited %0d cycles, required acceptance within 100", d, stall);
      end
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      in_data = 8'($urandom);
      in_last = 1'($urandom);
   endtask

   task automatic idle(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic pulse_reset();
      rst_n = 1'b0;
      in_valid = 1'b0;
      @(posedge clk);
      #1;
      rst_n = 1'b1;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      idle(2);
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b, required 0", out_valid); end
      checks++; if (out_data !== 32'h0) begin errors++; $display("FAIL reset_data: got %h, required 00000000", out_data); end
      checks++; if (out_keep !== 4'h0) begin errors++; $display("FAIL reset_keep: got %b, required 0000", out_keep); end
      checks++; if (out_last !== 1'b0) begin errors++; $display("FAIL reset_last: got %b, required 0", out_last); end
`ifdef BYTE_WORD_PACKER_PARITY_EN
      checks++; if (out_parity !== 4'h0) begin errors++; $display("FAIL reset_parity: got %b, required 0000", out_parity); end
`endif
      rst_n = 1'b1;
      checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %b, required 1", in_ready); end
      idle(1);
   endtask

   task automatic test_full_word();
      logic [7:0] b [4] = '{8'h11, 8'h22, 8'h33, 8'h44};
      int st;
      out_ready = 1'b1;
      for (int i = 0; i < 4; i++) begin
         send_byte(b[i], 1'b0, st);
         checks++; if (st !== 0) begin errors++; $display("FAIL full_in_ready: byte %0d stalled %0d, required 0", i, st); end
      end
      checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL full_latency: out_valid %b, required 1", out_valid); end
      checks++; if (out_data !== 32'h11223344) begin errors++; $display("FAIL full_data: got %h, required 11223344", out_data); end
      checks++; if (out_keep !== 4'b1111) begin errors++; $display("FAIL full_keep: got %b, required 1111", out_keep); end
      checks++; if (out_last !== 1'b0) begin errors++; $display("FAIL full_last: got %b, required 0", out_last); end
      idle(1);
   endtask

   task automatic test_partial();
      int st;
      out_ready = 1'b1;
      send_byte(8'hAA, 1'b0, st);
      send_byte(8'hBB, 1'b1, st);
      checks++; if (out_data !== 32'hAABB0000) begin errors++; $display("FAIL partial_data: got %h, required AABB0000", out_data); end
      checks++; if (out_keep !== 4'b1100) begin errors++; $display("FAIL partial_keep: got %b, required 1100", out_keep); end
      checks++; if (out_last !== 1'b1) begin errors++; $display("FAIL partial_last: got %b, required 1", out_last); end
      send_byte(8'h5A, 1'b1, st);
      checks++; if (out_data !== 32'h5A000000) begin errors++; $display("FAIL single_data: got %h, required 5A000000", out_data); end
      checks++; if (out_keep !== 4'b1000) begin errors++; $display("FAIL single_keep: got %b, required 1000", out_keep); end
      checks++; if (out_last !== 1'b1) begin errors++; $display("FAIL single_last: got %b, required 1", out_last); end
      idle(1);
   endtask

   task automatic test_backpressure();
      int st;
      out_ready = 1'b1;
      send_byte(8'hA1, 1'b0, st);
      send_byte(8'hA2, 1'b0, st);
      send_byte(8'hA3, 1'b0, st);
      send_byte(8'hA4, 1'b0, st);
      out_ready = 1'b0;
      in_valid = 1'b1;
      in_data = 8'hB0;
      in_last = 1'b1;
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL hold_in_ready: cycle %0d got %b, required 0", i, in_ready); end
         checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL hold_valid: cycle %0d got %b, required 1", i, out_valid); end
         checks++; if (out_data !== 32'hA1A2A3A4 || out_keep !== 4'hF) begin
            errors++; $display("FAIL hold_word: cycle %0d got %h/%b, required A1A2A3A4/1111", i, out_data, out_keep);
         end
         @(posedge clk);
         #1;
      end
      out_ready = 1'b1;
      @(negedge clk);
      checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL release_in_ready: got %b, required 1", in_ready); end
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      checks++; if (out_valid !== 1'b1 || out_data !== 32'hB0000000 || out_keep !== 4'b1000) begin
         errors++; $display("FAIL release_word: got v=%b %h/%b, required v=1 B0000000/1000", out_valid, out_data, out_keep);
      end
      idle(1);
   endtask

   task automatic test_back_to_back();
      logic [31:0] w [3] = '{32'h00010203, 32'h04050607, 32'h08090A0B};
      int st;
      out_ready = 1'b1;
      got_q.delete();
      hs_q.delete();
      for (int i = 0; i < 12; i++) begin
         send_byte(8'(i), 1'b0, st);
         checks++; if (st !== 0) begin errors++; $display("FAIL stream_in_ready: byte %0d stalled %0d, required 0", i, st); end
      end
      idle(2);
      checks++;
      if (got_q.size() != 3) begin
         errors++; $display("FAIL stream_count: got %0d words, required 3", got_q.size());
      end else begin
         for (int i = 0; i < 3; i++) begin
            checks++; if (got_q[i] !== w[i]) begin errors++; $display("FAIL stream_word%0d: got %h, required %h", i, got_q[i], w[i]); end
         end
         for (int i = 1; i < 3; i++) begin
            checks++; if (hs_q[i] - hs_q[i-1] != 4) begin
               errors++; $display("FAIL stream_spacing%0d: got %0d cycles, required 4", i, hs_q[i] - hs_q[i-1]);
            end
         end
      end
   endtask

   task automatic test_ignore_idle();
      int st;
      out_ready = 1'b1;
      in_valid = 1'b0;
      for (int i = 0; i < 5; i++) begin
         in_data = 8'($urandom);
         in_last = 1'b1;
         @(negedge clk);
         checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL ignore_valid: cycle %0d got %b, required 0", i, out_valid); end
         @(posedge clk);
         #1;
      end
      send_byte(8'h77, 1'b0, st);
      send_byte(8'h88, 1'b1, st);
      checks++; if (out_data !== 32'h77880000 || out_keep !== 4'b1100) begin
         errors++; $display("FAIL ignore_word: got %h/%b, required 77880000/1100", out_data, out_keep);
      end
      idle(1);
   endtask

   task automatic test_reset_mid();
      int st;
      out_ready = 1'b0;
      send_byte(8'hE0, 1'b1, st);
      pulse_reset();
      checks++; if (out_valid !== 1'b0 || out_data !== 32'h0 || out_keep !== 4'h0) begin
         errors++; $display("FAIL midreset_out: got v=%b %h/%b, required v=0 00000000/0000", out_valid, out_data, out_keep);
      end
      checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL midreset_in_ready: got %b, required 1", in_ready); end
      out_ready = 1'b1;
      send_byte(8'hC0, 1'b0, st);
      send_byte(8'hC1, 1'b0, st);
      pulse_reset();
      got_q.delete();
      for (int i = 1; i <= 4; i++) send_byte(8'(i), 1'b0, st);
      idle(2);
      checks++;
      if (got_q.size() != 1) begin
         errors++; $display("FAIL midreset_count: got %0d words, required 1", got_q.size());
      end else begin
         checks++; if (got_q[0] !== 32'h01020304) begin errors++; $display("FAIL midreset_word: got %h, required 01020304", got_q[0]); end
      end
   endtask

`ifdef BYTE_WORD_PACKER_PARITY_EN
   task automatic test_parity();
      int st;
      out_ready = 1'b1;
      send_byte(8'h01, 1'b0, st);
      send_byte(8'h03, 1'b0, st);
      send_byte(8'h07, 1'b1, st);
      checks++; if (out_data !== 32'h01030700 || out_keep !== 4'b1110) begin
         errors++; $display("FAIL parity_word: got %h/%b, required 01030700/1110", out_data, out_keep);
      end
      checks++; if (out_parity !== 4'b1010) begin errors++; $display("FAIL parity_bits: got %b, required 1010", out_parity); end
      idle(1);
   endtask
`endif

   initial begin
      test_reset();
      test_full_word();
      test_partial();
      test_backpressure();
      test_back_to_back();
      test_ignore_idle();
      test_reset_mid();
`ifdef BYTE_WORD_PACKER_PARITY_EN
      test_parity();
`endif
      idle(2);
      checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL drain: %0d expected words left, required 0", exp_q.size()); end
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
